// File: rtl/coin_sensor_multi.sv
// Serial coin diameter classifier: captures a write-framed diameter word, checks its length
// and matches it against NUM_COINS [lo,hi] windows. Optional stuck-strobe timeout: COIN_SENSOR_TIMEOUT_EN.
module coin_sensor_multi #(
  parameter int                          DIAM_W      = 10,
  parameter int                          NUM_COINS   = 4,
  parameter logic [NUM_COINS*DIAM_W-1:0] COIN_LO     = {10'h3CC, 10'h2CC, 10'h351, 10'h2FA},
  parameter logic [NUM_COINS*DIAM_W-1:0] COIN_HI     = {10'h3D7, 10'h2D7, 10'h35C, 10'h305},
  parameter int                          TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serialIn,
  input  logic                 write,
  output logic [NUM_COINS-1:0] coin,
  output logic                 coin_valid,
  output logic                 reject,
  output logic [DIAM_W-1:0]    diameter,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_EVAL  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Bit counter must reach DIAM_W+1 so an overlong frame stays distinguishable.
  localparam int               CNT_W    = $clog2(DIAM_W + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIAM_W);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(DIAM_W + 1);

  state_t                 state_q;
  logic [DIAM_W-1:0]      diameter_q;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [NUM_COINS-1:0]   coin_q;
  logic                   coin_valid_q;
  logic                   reject_q;
  logic [NUM_COINS-1:0]   match_d;
  logic                   hit_d;

`ifdef COIN_SENSOR_TIMEOUT_EN
  localparam int               TMO_W   = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_q;
  logic             lock_q;
`endif

  // Window match on the captured word; the ascending scan makes the lowest index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match_d = '0;
    hit_d   = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (!hit_d &&
          diameter_q >= COIN_LO[i*DIAM_W +: DIAM_W] &&
          diameter_q <= COIN_HI[i*DIAM_W +: DIAM_W]) begin
        match_d[i] = 1'b1;
        hit_d      = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      diameter_q   <= '0;
      bitcnt_q     <= '0;
      coin_q       <= '0;
      coin_valid_q <= 1'b0;
      reject_q     <= 1'b0;
`ifdef COIN_SENSOR_TIMEOUT_EN
      tmo_q        <= '0;
      lock_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef COIN_SENSOR_TIMEOUT_EN
          if (!write) lock_q <= 1'b0;
          if (write && !lock_q) begin
            tmo_q <= TMO_W'(1);
`else
          if (write) begin
`endif
            state_q    <= ST_SHIFT;
            diameter_q <= {{(DIAM_W-1){1'b0}}, serialIn};
            bitcnt_q   <= CNT_ONE;
          end
        end

        ST_SHIFT: begin
          if (write) begin
            diameter_q <= {diameter_q[DIAM_W-2:0], serialIn};
            if (bitcnt_q != CNT_OVER) bitcnt_q <= bitcnt_q + 1'b1;
`ifdef COIN_SENSOR_TIMEOUT_EN
            tmo_q <= tmo_q + 1'b1;
            // This edge is the (TIMEOUT_CYC+1)-th write-high sample: abandon the frame.
            if (tmo_q == TMO_LIM) begin
              state_q  <= ST_DONE;
              reject_q <= 1'b1;
              lock_q   <= 1'b1;
            end
`endif
          end else begin
            state_q <= ST_EVAL;
          end
        end

        ST_EVAL: begin
          state_q <= ST_DONE;
          if (bitcnt_q == CNT_FULL && hit_d) begin
            coin_q       <= match_d;
            coin_valid_q <= 1'b1;
          end else begin
            reject_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q      <= ST_IDLE;
          coin_q       <= '0;
          coin_valid_q <= 1'b0;
          reject_q     <= 1'b0;
`ifdef COIN_SENSOR_TIMEOUT_EN
          if (!write) lock_q <= 1'b0;
`endif
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign coin       = coin_q;
  assign coin_valid = coin_valid_q;
  assign reject     = reject_q;
  assign diameter   = diameter_q;
  assign state      = state_q;

endmodule
